// File: rtl/ah_wrr_arbiter.sv
// ah_wrr_arbiter: weighted round-robin arbiter with per-requester credit
// counters, a plain round-robin mode, forced credit reload and an encoded
// grant index. One registered one-hot grant per cycle.
//
// Request/grant protocol: a requester raises req[i] and holds it until it
// sees grant[i] high. grant is the registered result of the req sampled at
// the previous rising edge. Dropping req before the grant forfeits the slot,
// and nothing records that it was dropped.
module ah_wrr_arbiter #(
  parameter int N   = 8,
  parameter int WW  = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] cfg_weight,
  input  logic            wrr_en,
  input  logic            cfg_reload,
  output logic [N-1:0]    grant,
  output logic            grant_vld,
  output logic [IDW-1:0]  grant_id,
  output logic            refresh
);

  logic [WW-1:0]  credit   [N];
  logic [WW-1:0]  credit_n [N];
  logic [WW-1:0]  w_eff    [N];
  logic [WW-1:0]  base     [N];
  logic [IDW-1:0] ptr, ptr_n;
  logic           pend_reload, pend_n;
  logic [N-1:0]   elig_cur, elig;
  logic           do_refresh;
  logic           found;
  logic [IDW-1:0] win;
  logic [N-1:0]   win_oh;
  logic           win_last;

  // Effective weights (0 counts as 1), current eligibility, and the credit
  // values the arbitration works from (reloaded ones on a refresh).
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_eff[i]    = (cfg_weight[i*WW +: WW] == '0) ? WW'(1) : cfg_weight[i*WW +: WW];
      elig_cur[i] = req[i] && (credit[i] != '0);
    end
    do_refresh = wrr_en && (req != '0) && ((elig_cur == '0) || pend_reload);
    for (int i = 0; i < N; i++) begin
      base[i] = do_refresh ? w_eff[i] : credit[i];
    end
    if (!wrr_en || do_refresh) elig = req;
    else                       elig = elig_cur;
  end

  // Rotating priority scan: first eligible index starting at ptr.
  always_comb begin
    int idx;
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && elig[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    if (found) win_oh[win] = 1'b1;
  end

  // Next credit, pointer and pending-reload state.
  always_comb begin
    win_last = (base[win] == WW'(1));
    for (int i = 0; i < N; i++) begin
      credit_n[i] = credit[i];
      if (wrr_en && found) begin
        credit_n[i] = win_oh[i] ? (base[i] - WW'(1)) : base[i];
      end
    end
    ptr_n = ptr;
    if (found) begin
      if (wrr_en && !win_last)  ptr_n = win;
      else if (win == IDW'(N-1)) ptr_n = '0;
      else                       ptr_n = win + IDW'(1);
    end
    pend_n = do_refresh ? 1'b0 : (pend_reload | cfg_reload);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr         <= '0;
      pend_reload <= 1'b0;
      for (int i = 0; i < N; i++) credit[i] <= '0;
      grant       <= '0;
      grant_vld   <= 1'b0;
      grant_id    <= '0;
      refresh     <= 1'b0;
    end else begin
      ptr         <= ptr_n;
      pend_reload <= pend_n;
      for (int i = 0; i < N; i++) credit[i] <= credit_n[i];
      grant       <= win_oh;
      grant_vld   <= found;
      grant_id    <= found ? win : '0;
      refresh     <= do_refresh;
    end
  end

endmodule

// File: tb/tb_ah_wrr_arbiter.sv
// Bench for ah_wrr_arbiter (N=4, WW=4): directed scenarios plus a randomized
// run, compared cycle by cycle against a behavioural model of the arbiter.
module tb_ah_wrr_arbiter;

  localparam int N   = 4;
  localparam int WW  = 4;
  localparam int IDW = 2;
  localparam int W   = 2 + IDW + N;  // {refresh, grant_vld, grant_id, grant}

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req;
  logic [N*WW-1:0] cfg_weight;
  logic            wrr_en;
  logic            cfg_reload;
  logic [N-1:0]    grant;
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  logic            refresh;

  always #5 clk = ~clk;

  ah_wrr_arbiter #(.N(N), .WW(WW), .IDW(IDW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .cfg_weight (cfg_weight),
    .wrr_en     (wrr_en),
    .cfg_reload (cfg_reload),
    .grant      (grant),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id),
    .refresh    (refresh)
  );

  // ---------------- scoreboard / model state ----------------
  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int wt[N];
  int m_cred[N];
  int m_ptr;
  bit m_pend;

  function automatic logic [W-1:0] observed();
    return {refresh, grant_vld, grant_id, grant};
  endfunction

  // Behavioural model: weighted round robin described as "each requester
  // holds a budget of grants per round; the round restarts when no pending
  // requester has budget left (or a reload is pending)".
  task automatic model_step(input logic [N-1:0] r, input logic w_en,
                            input logic rl, input logic rs);
    logic [W-1:0] e;
    logic [N-1:0] oh;
    int win;
    bit rf, any;
    int i;
    e = '0; oh = '0; win = -1; rf = 0;
    if (!rs) begin
      m_ptr = 0; m_pend = 0;
      for (int j = 0; j < N; j++) m_cred[j] = 0;
    end else begin
      if (r != 0) begin
        if (w_en) begin
          any = 0;
          for (int j = 0; j < N; j++) if (r[j] && m_cred[j] > 0) any = 1;
          if (!any || m_pend) begin
            rf = 1; m_pend = 0;
            for (int j = 0; j < N; j++) m_cred[j] = (wt[j] == 0) ? 1 : wt[j];
          end
          for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (win < 0 && r[i] && m_cred[i] > 0) win = i;
          end
          m_cred[win] = m_cred[win] - 1;
          m_ptr = (m_cred[win] > 0) ? win : (win + 1) % N;
        end else begin
          for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (win < 0 && r[i]) win = i;
          end
          m_ptr = (win + 1) % N;
        end
      end
      if (rl && !rf) m_pend = 1;
    end
    if (win >= 0) begin
      oh[win] = 1'b1;
      e = {rf, 1'b1, IDW'(win), oh};
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [N-1:0] r, input logic w_en,
                       input logic rl, input logic rs);
    req = r; wrr_en = w_en; cfg_reload = rl; rstn = rs;
    for (int j = 0; j < N; j++) cfg_weight[j*WW +: WW] = wt[j][WW-1:0];
    model_step(r, w_en, rl, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic set_wt(input int w0, input int w1, input int w2, input int w3);
    wt[0] = w0; wt[1] = w1; wt[2] = w2; wt[3] = w3;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e, g;
    set_wt(3, 1, 2, 1);
    for (int c = 0; c < 3; c++) begin
      drive(4'hF, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front(); g = observed();
      n_total++;
      if (g !== e || g !== '0) $display("FAIL reset c%0d: got %b expected %b", c, g, e);
      else n_pass++;
    end
  endtask

  task automatic test_weighted_round();
    logic [W-1:0] e, g;
    int ids[7] = '{0, 0, 0, 1, 2, 2, 3};
    set_wt(3, 1, 2, 1);
    drive(4'h0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int c = 0; c < 14; c++) begin
      drive(4'hF, 1'b1, 1'b0, 1'b1);
      e = exp_q.pop_front(); g = observed();
      n_total++;
      if (g !== e) $display("FAIL weighted c%0d: got %b expected %b", c, g, e);
      else n_pass++;
      n_total++;
      if (grant_id !== IDW'(ids[c % 7]) || refresh !== ((c % 7) == 0))
        $display("FAIL weighted_seq c%0d: got id %0d rf %b expected id %0d rf %b",
                 c, grant_id, refresh, ids[c % 7], (c % 7) == 0);
      else n_pass++;
    end
  endtask

  task automatic test_plain();
    logic [W-1:0] e, g;
    set_wt(2, 2, 2, 2);
    drive(4'h0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int c = 0; c < 14; c++) begin
      drive(4'hF, (c >= 2 && c < 7) ? 1'b0 : 1'b1, 1'b0, 1'b1);
      e = exp_q.pop_front(); g = observed();
      n_total++;
      if (g !== e) $display("FAIL plain c%0d: got %b expected %b", c, g, e);
      else n_pass++;
    end
  endtask

  task automatic test_partial();
    logic [W-1:0] e, g;
    int ids[5] = '{1, 1, 3, 3, 1};
    set_wt(2, 2, 2, 2);
    drive(4'h0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int c = 0; c < 5; c++) begin
      drive(4'b1010, 1'b1, 1'b0, 1'b1);
      e = exp_q.pop_front(); g = observed();
      n_total++;
      if (g !== e || grant_id !== IDW'(ids[c]) || refresh !== (c == 0 || c == 4))
        $display("FAIL partial c%0d: got %b expected %b", c, g, e);
      else n_pass++;
    end
  endtask

  task automatic test_zero_weight();
    logic [W-1:0] e, g;
    set_wt(0, 0, 0, 2);
    drive(4'h0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int c = 0; c < 12; c++) begin
      drive(4'hF, 1'b1, 1'b0, 1'b1);
      e = exp_q.pop_front(); g = observed();
      n_total++;
      if (g !== e) $display("FAIL zero_wt c%0d: got %b expected %b", c, g, e);
      else n_pass++;
    end
  endtask

  task automatic test_reload();
    logic [W-1:0] e, g;
    logic [N-1:0] r;
    logic rl;
    set_wt(3, 1, 2, 1);
    drive(4'h0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int c = 0; c < 14; c++) begin
      r  = (c >= 7 && c < 10) ? 4'h0 : 4'hF;
      rl = (c == 3 || c == 7);
      if (c == 3) set_wt(1, 1, 1, 1);
      drive(r, 1'b1, rl, 1'b1);
      e = exp_q.pop_front(); g = observed();
      n_total++;
      if (g !== e) $display("FAIL reload c%0d: got %b expected %b", c, g, e);
      else n_pass++;
      if (c == 4 || c == 10) begin
        n_total++;
        if (refresh !== 1'b1) $display("FAIL reload_rf c%0d: got %b expected 1", c, refresh);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e, g;
    set_wt(3, 1, 2, 1);
    drive(4'h0, 1'b1, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    for (int c = 0; c < 6; c++) begin
      drive(4'hF, 1'b1, 1'b0, (c == 2) ? 1'b0 : 1'b1);
      e = exp_q.pop_front(); g = observed();
      n_total++;
      if (g !== e) $display("FAIL reset_mid c%0d: got %b expected %b", c, g, e);
      else n_pass++;
      if (c == 2 || c == 3) begin
        n_total++;
        if ((c == 2 && grant !== '0) || (c == 3 && (grant_id !== '0 || refresh !== 1'b1)))
          $display("FAIL reset_mid_dir c%0d: got id %0d rf %b grant %b", c, grant_id, refresh, grant);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e, g;
    logic [N-1:0] r;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 19) == 0)
        for (int j = 0; j < N; j++) wt[j] = $urandom_range(0, 15);
      r = N'($urandom_range(0, 15));
      drive(r, $urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) != 0);
      e = exp_q.pop_front(); g = observed();
      n_total++;
      if (g !== e) $display("FAIL random c%0d: got %b expected %b", c, g, e);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rstn = 1'b0; req = '0; cfg_weight = '0; wrr_en = 1'b1; cfg_reload = 1'b0;
    for (int j = 0; j < N; j++) begin
      wt[j] = 1; m_cred[j] = 0;
    end
    m_ptr = 0; m_pend = 0;
    test_reset();
    test_weighted_round();
    test_plain();
    test_partial();
    test_zero_weight();
    test_reload();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
